// File: rtl/acc_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_alu_pkg
//  Description : Shared opcode and state encodings for the accumulator ALU.
//                OPC_* localparams fix the 3-bit opcode encodings, and the
//                enums are built on them so that the control unit and the ALU
//                agree on one table.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_alu_pkg;

  // Opcode encodings as seen on the op port
  localparam logic [2:0] OPC_ADD = 3'd0;
  localparam logic [2:0] OPC_ADC = 3'd1;
  localparam logic [2:0] OPC_SUB = 3'd2;
  localparam logic [2:0] OPC_AND = 3'd3;
  localparam logic [2:0] OPC_XOR = 3'd4;
  localparam logic [2:0] OPC_SHL = 3'd5;
  localparam logic [2:0] OPC_SHR = 3'd6;
  localparam logic [2:0] OPC_MUL = 3'd7;

  typedef enum logic [2:0] {
    OP_ADD = OPC_ADD,
    OP_ADC = OPC_ADC,
    OP_SUB = OPC_SUB,
    OP_AND = OPC_AND,
    OP_XOR = OPC_XOR,
    OP_SHL = OPC_SHL,
    OP_SHR = OPC_SHR,
    OP_MUL = OPC_MUL
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage : acc_alu_pkg
`default_nettype wire

// File: rtl/acc_alu_shift_add_mul.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mul
//  Description : Iterative W x W unsigned multiplier, one shift-add step per
//                clock, LSB of the multiplier first. A go pulse latches the
//                operands and clears the product; W clocks later the step
//                flagged by last completes the product.
//  Ports       : clk, reset (sync, active-high)
//                go      - latch a/b, clear product, begin iterating
//                a, b    - W-bit operands (sampled on go)
//                last    - high during the final iteration
//                product - 2W-bit product including the current step; it is
//                          the complete result while last is high
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul
  import acc_alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             last,
  output logic [2*W-1:0]   product
);

  localparam int CW = $clog2(W);

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  mcand_q;
  logic [W-1:0]    mplier_q;
  logic [2*W-1:0]  prod_q;
  logic [2*W-1:0]  prod_d;

  // Current step's partial product is folded in combinationally so the
  // caller can capture the finished result on the same edge that ends it.
  always_comb begin
    prod_d = prod_q;
    if (mplier_q[0]) begin
      prod_d = prod_q + mcand_q;
    end
  end

  assign product = prod_d;
  assign last    = run_q && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (go) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      prod_q   <= '0;
    end else if (run_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule : shift_add_mul
`default_nettype wire

// File: rtl/acc_alu.sv
`default_nettype none
// ============================================================================
//  Module      : acc_alu
//  Description : Sequential accumulator ALU. Single-cycle ADD/ADC/SUB/AND/
//                XOR/SHL/SHR operate on the operands present with start; the
//                result, carry and zero flags are registered on entry to DONE
//                and held until the next operation completes.
//                Optional macro ACC_ALU_MUL_EN adds a W-cycle shift-add MUL
//                (op 7). Without it op 7 completes in one cycle with no write
//                and leaves data/carry/zero untouched.
//  Ports       : clk, reset (sync, active-high)
//                start/op/dest/acc_in/reg_in - request from control unit
//                busy, done                  - handshake back to control
//                write_enabled, reg_write_number, reg_write_data
//                                            - register-file write port
//                carry, zero                 - status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_alu
  import acc_alu_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [D-1:0]  dest,
  input  logic [W-1:0]  acc_in,
  input  logic [W-1:0]  reg_in,
  output logic          busy,
  output logic          done,
  output logic          write_enabled,
  output logic [D-1:0]  reg_write_number,
  output logic [W-1:0]  reg_write_data,
  output logic          carry,
  output logic          zero
);

  localparam int SW = $clog2(W);

  alu_state_t      state_q;
  logic            busy_q;
  logic            done_q;
  logic            we_q;
  logic [D-1:0]    num_q;
  logic [W-1:0]    data_q;
  logic            carry_q;
  logic            zero_q;

  // --------------------------------------------------------------------------
  // Single-cycle datapath
  // --------------------------------------------------------------------------
  logic [SW-1:0]   w_shamt;
  logic [W:0]      w_add;
  logic [W:0]      w_sub;
  logic [W:0]      w_shl;
  logic [W:0]      w_shr;
  logic [W-1:0]    w_res;
  logic            w_cout;

  assign w_shamt = reg_in[SW-1:0];

  // ADC shares the adder with ADD; the carry-in is gated by the opcode.
  assign w_add = {1'b0, acc_in} + {1'b0, reg_in}
               + {{W{1'b0}}, (op == OPC_ADC) & carry_q};
  // Bit W of the widened difference is set exactly when acc_in < reg_in.
  assign w_sub = {1'b0, acc_in} - {1'b0, reg_in};
  // One guard bit on each shift catches the last bit shifted out.
  assign w_shl = {1'b0, acc_in} << w_shamt;
  assign w_shr = {acc_in, 1'b0} >> w_shamt;

  always_comb begin
    w_res  = acc_in;
    w_cout = carry_q;
    case (alu_op_t'(op))
      OP_ADD, OP_ADC: begin
        w_res  = w_add[W-1:0];
        w_cout = w_add[W];
      end
      OP_SUB: begin
        w_res  = w_sub[W-1:0];
        w_cout = w_sub[W];
      end
      OP_AND: w_res = acc_in & reg_in;
      OP_XOR: w_res = acc_in ^ reg_in;
      OP_SHL: begin
        w_res = w_shl[W-1:0];
        if (w_shamt != '0) begin
          w_cout = w_shl[W];
        end
      end
      OP_SHR: begin
        w_res = w_shr[W:1];
        if (w_shamt != '0) begin
          w_cout = w_shr[0];
        end
      end
      default: begin
        w_res  = acc_in;
        w_cout = carry_q;
      end
    endcase
  end

`ifdef ACC_ALU_MUL_EN
  // --------------------------------------------------------------------------
  // Multi-cycle multiplier
  // --------------------------------------------------------------------------
  logic            w_mul_go;
  logic            w_mul_last;
  logic [2*W-1:0]  w_mul_prod;

  assign w_mul_go = (state_q == ST_IDLE) && start && (op == OPC_MUL);

  shift_add_mul #(
    .W (W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .go      (w_mul_go),
    .a       (acc_in),
    .b       (reg_in),
    .last    (w_mul_last),
    .product (w_mul_prod)
  );
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      num_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          we_q   <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            num_q  <= dest;
            if (op == OPC_MUL) begin
`ifdef ACC_ALU_MUL_EN
              state_q <= ST_MUL;
`else
              // Unimplemented op: complete immediately without a write and
              // without disturbing the held result or flags.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              we_q    <= 1'b0;
`endif
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              we_q    <= 1'b1;
              data_q  <= w_res;
              carry_q <= w_cout;
              zero_q  <= (w_res == '0);
            end
          end
        end
`ifdef ACC_ALU_MUL_EN
        ST_MUL: begin
          if (w_mul_last) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            we_q    <= 1'b1;
            data_q  <= w_mul_prod[W-1:0];
            carry_q <= |w_mul_prod[2*W-1:W];
            zero_q  <= (w_mul_prod[W-1:0] == '0);
          end
        end
`endif
        ST_DONE: begin
          // start is deliberately not looked at here
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign write_enabled    = we_q;
  assign reg_write_number = num_q;
  assign reg_write_data   = data_q;
  assign carry            = carry_q;
  assign zero             = zero_q;

endmodule : acc_alu
`default_nettype wire

// File: tb/tb_acc_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_alu
//  Description : Self-checking bench for acc_alu. A transaction-level model
//                predicts every output each cycle from the operation rules;
//                directed vectors pin results with hand-computed literals.
//                MUL vectors are exercised when ACC_ALU_MUL_EN is defined,
//                the illegal-op-7 behaviour otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_alu;

  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [D-1:0]  dest = '0;
  logic [W-1:0]  acc_in = '0;
  logic [W-1:0]  reg_in = '0;
  logic          busy, done, write_enabled, carry, zero;
  logic [D-1:0]  reg_write_number;
  logic [W-1:0]  reg_write_data;

  acc_alu #(.W(W), .D(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .dest             (dest),
    .acc_in           (acc_in),
    .reg_in           (reg_in),
    .busy             (busy),
    .done             (done),
    .write_enabled    (write_enabled),
    .reg_write_number (reg_write_number),
    .reg_write_data   (reg_write_data),
    .carry            (carry),
    .zero             (zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: {carry, data} from plain integer arithmetic
  // --------------------------------------------------------------------------
  function automatic logic [8:0] alu_model(input int o, input int a, input int b, input bit c);
    int n;
    int s;
    logic [8:0] r;
    n = b % 8;
    r = {c, a[7:0]};
    case (o)
      0: begin s = a + b;     r = {s > 255, s[7:0]}; end
      1: begin s = a + b + c; r = {s > 255, s[7:0]}; end
      2: begin s = a - b;     r = {a < b, s[7:0]};   end
      3: begin s = a & b;     r = {c, s[7:0]};       end
      4: begin s = a ^ b;     r = {c, s[7:0]};       end
      5: if (n != 0) begin s = a * (1 << n); r = {s > 255 ? ((a >> (8 - n)) & 1) == 1 : 1'b0, s[7:0]}; end
      6: if (n != 0) begin s = a / (1 << n); r = {((a >> (n - 1)) & 1) == 1, s[7:0]}; end
      default: r = {c, a[7:0]};
    endcase
    return r;
  endfunction

  function automatic logic [8:0] mul_model(input int a, input int b);
    int p;
    p = a * b;
    return {p > 255, p[7:0]};
  endfunction

  function automatic bit low_zero(input logic [8:0] r);
    return r[7:0] == 8'd0;
  endfunction

  bit          m_busy, m_done, m_we, m_carry, m_zero;
  logic [3:0]  m_num;
  logic [7:0]  m_data;
  int          m_remain, m_pa, m_pb;

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_done <= 0; m_we <= 0; m_carry <= 0; m_zero <= 0;
      m_num <= '0; m_data <= '0; m_remain <= 0;
    end else if (m_done) begin
      m_busy <= 0; m_done <= 0; m_we <= 0;
    end else if (m_busy) begin
      m_remain <= m_remain - 1;
      if (m_remain == 1) begin
        {m_carry, m_data} <= mul_model(m_pa, m_pb);
        m_zero <= low_zero(mul_model(m_pa, m_pb));
        m_done <= 1; m_we <= 1;
      end
    end else if (start) begin
      m_busy <= 1;
      m_num  <= dest;
      if (op == 3'd7) begin
`ifdef ACC_ALU_MUL_EN
        m_pa <= int'(acc_in); m_pb <= int'(reg_in); m_remain <= W;
`else
        m_done <= 1; m_we <= 0;
`endif
      end else begin
        {m_carry, m_data} <= alu_model(int'(op), int'(acc_in), int'(reg_in), m_carry);
        m_zero <= low_zero(alu_model(int'(op), int'(acc_in), int'(reg_in), m_carry));
        m_done <= 1; m_we <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy",  busy,             m_busy);
      chk("cyc_done",  done,             m_done);
      chk("cyc_we",    write_enabled,    m_we);
      chk("cyc_num",   reg_write_number, m_num);
      chk("cyc_data",  reg_write_data,   m_data);
      chk("cyc_carry", carry,            m_carry);
      chk("cyc_zero",  zero,             m_zero);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  // Issues one request and returns 1ns into the done cycle with the latency
  // in cycles counted from the accepting edge.
  task automatic run_op(input logic [2:0] o, input logic [3:0] d,
                        input logic [7:0] a, input logic [7:0] b, output int lat);
    @(posedge clk); #1;
    start = 1'b1; op = o; dest = d; acc_in = a; reg_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic expect_res(input string name, input logic [7:0] d, input bit c,
                            input bit z, input bit we, input logic [3:0] num);
    chk({name, "_done"},  done,             1'b1);
    chk({name, "_we"},    write_enabled,    we);
    chk({name, "_data"},  reg_write_data,   d);
    chk({name, "_carry"}, carry,            c);
    chk({name, "_zero"},  zero,             z);
    chk({name, "_num"},   reg_write_number, num);
  endtask

  int lat;
  int seen;

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy",  busy, 1'b0);
    chk("rst_done",  done, 1'b0);
    chk("rst_we",    write_enabled, 1'b0);
    chk("rst_data",  reg_write_data, 8'h00);
    chk("rst_num",   reg_write_number, 4'h0);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero",  zero, 1'b0);
    reset = 1'b0;

    run_op(3'd0, 4'd3, 8'hF0, 8'h20, lat); chk("add_lat", lat, 1);
    expect_res("add", 8'h10, 1'b1, 1'b0, 1'b1, 4'd3);
    run_op(3'd1, 4'd5, 8'h01, 8'h01, lat); expect_res("adc", 8'h03, 1'b0, 1'b0, 1'b1, 4'd5);
    run_op(3'd2, 4'd1, 8'h05, 8'h07, lat); expect_res("sub", 8'hFE, 1'b1, 1'b0, 1'b1, 4'd1);
    run_op(3'd5, 4'd2, 8'h81, 8'h01, lat); expect_res("shl", 8'h02, 1'b1, 1'b0, 1'b1, 4'd2);
    run_op(3'd6, 4'd2, 8'h10, 8'h00, lat); expect_res("shr0", 8'h10, 1'b1, 1'b0, 1'b1, 4'd2);
    run_op(3'd3, 4'd4, 8'hF0, 8'h3C, lat); expect_res("and", 8'h30, 1'b1, 1'b0, 1'b1, 4'd4);
    run_op(3'd4, 4'd4, 8'h5A, 8'h5A, lat); expect_res("xor", 8'h00, 1'b1, 1'b1, 1'b1, 4'd4);
    run_op(3'd0, 4'd6, 8'h01, 8'h01, lat); expect_res("add2", 8'h02, 1'b0, 1'b0, 1'b1, 4'd6);
    run_op(3'd6, 4'd7, 8'h03, 8'h09, lat); expect_res("shr9", 8'h01, 1'b1, 1'b0, 1'b1, 4'd7);
    run_op(3'd5, 4'd7, 8'h40, 8'h02, lat); expect_res("shl2", 8'h00, 1'b1, 1'b1, 1'b1, 4'd7);

    // start held into the DONE cycle must be ignored
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; dest = 4'd8; acc_in = 8'hFF; reg_in = 8'hFF;
    @(posedge clk); #1;
    expect_res("hold", 8'hFE, 1'b1, 1'b0, 1'b1, 4'd8);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_busy", busy, 1'b0);
    chk("hold_done", done, 1'b0);

`ifdef ACC_ALU_MUL_EN
    run_op(3'd7, 4'd8, 8'h0D, 8'h0B, lat); chk("mul_lat", lat, 9);
    expect_res("mul", 8'h8F, 1'b0, 1'b0, 1'b1, 4'd8);
    run_op(3'd7, 4'd9, 8'h10, 8'h10, lat); expect_res("mul256", 8'h00, 1'b1, 1'b1, 1'b1, 4'd9);

    // start pulsed while multiplying is dropped
    @(posedge clk); #1;
    start = 1'b1; op = 3'd7; dest = 4'hA; acc_in = 8'h03; reg_in = 8'h05;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; dest = 4'h0; acc_in = 8'hFF; reg_in = 8'hFF;
    @(posedge clk); #1; start = 1'b0;
    lat = 3;
    while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
    chk("mulmid_lat", lat, 9);
    expect_res("mulmid", 8'h0F, 1'b0, 1'b0, 1'b1, 4'hA);

    // reset during the 4th multiply cycle
    @(posedge clk); #1;
    start = 1'b1; op = 3'd7; dest = 4'hC; acc_in = 8'hFF; reg_in = 8'hFF;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mulrst_busy_pre", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mulrst_busy", busy, 1'b0);
    chk("mulrst_data", reg_write_data, 8'h00);
    chk("mulrst_num",  reg_write_number, 4'h0);
    chk("mulrst_carry", carry, 1'b0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || write_enabled) seen++;
    end
    chk("mulrst_nodone", seen, 0);
`else
    run_op(3'd7, 4'hB, 8'h55, 8'hAA, lat); chk("ill_lat", lat, 1);
    expect_res("ill", 8'hFE, 1'b1, 1'b0, 1'b0, 4'hB);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_data",  reg_write_data, 8'h00);
    chk("rst2_carry", carry, 1'b0);
`endif

    run_op(3'd0, 4'd2, 8'h12, 8'h34, lat); chk("post_lat", lat, 1);
    expect_res("post", 8'h46, 1'b0, 1'b0, 1'b1, 4'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_acc_alu
`default_nettype wire
